// File: rtl/encoder_param_stream_loader.sv
// Run-time loader for encoder parameters: a valid/ready beat stream fills an
// internal RAM in order, which is then read through a 2-stage addr/ce/q port.
module encoder_param_stream_loader #(
  parameter int PRECISION_0       = 16,
  parameter int PRECISION_1       = 3,
  parameter int TENSOR_SIZE_DIM_0 = 32,
  parameter int PARALLELISM_DIM_0 = 1,
  parameter int PARALLELISM_DIM_1 = 1,
  localparam int DEPTH      = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0,
  localparam int LANES      = PARALLELISM_DIM_0 * PARALLELISM_DIM_1,
  localparam int ADDR_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PRECISION_0-1:0]         data_in [LANES],
  input  logic                           data_in_valid,
  output logic                           data_in_ready,
  input  logic                           reload,
  output logic                           load_done,
  input  logic [ADDR_WIDTH-1:0]          address0,
  input  logic                           ce0,
  output logic [PRECISION_0*LANES-1:0]   q0
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WORD_W = PRECISION_0 * LANES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  // The fractional-bit count only describes the stored format; nothing here scales data.
  if (PRECISION_1 >= PRECISION_0) begin : g_frac_wider_than_word
  end

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [WORD_W-1:0] stage1_q;
  logic [WORD_W-1:0] q0_q;
  logic [WORD_W-1:0] beat;
  logic [WORD_W-1:0] rd_word;
  logic              wr_en;

  logic [WORD_W-1:0] ram [DEPTH];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned -- that is what keeps these blocks from inferring latches.
  always_comb begin
    beat = '0;
    for (int j = 0; j < LANES; j++) begin
      beat[PRECISION_0*j +: PRECISION_0] = data_in[j];
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    data_in_ready = 1'b0;
    load_done     = (state_q == ST_DONE);
    unique case (state_q)
      ST_LOAD: begin
        data_in_ready = !reload;
        if (reload) begin
          wr_ptr_d = '0;
        end else if (data_in_valid) begin
          if (wr_ptr_q == LAST_IDX) begin
            wr_ptr_d = '0;
            state_d  = ST_DONE;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (reload) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
        end
      end
      default: begin
        state_d  = ST_LOAD;
        wr_ptr_d = '0;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LOAD;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign wr_en = data_in_valid && data_in_ready && !rst;

  // NOTE: the RAM array is deliberately left out of reset; clearing it would
  // force a flop array, and a fresh load overwrites it from address 0 anyway.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wr_ptr_q] <= beat;
    end
  end

  // Out-of-range addresses read as zero; the write pointer never goes there.
  assign rd_word = (address0 < DEPTH_A) ? ram[address0[IDX_W-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_q <= '0;
      q0_q     <= '0;
    end else if (ce0) begin
      stage1_q <= rd_word;
      q0_q     <= stage1_q;
    end
  end

  assign q0 = q0_q;

endmodule

// File: tb/tb_encoder_param_stream_loader.sv
// Scoreboard bench for encoder_param_stream_loader: a 1-lane instance for the
// load/read/reload/reset flows and a 2-lane instance for beat packing.
module tb_encoder_param_stream_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in [1];
  logic        data_in_valid;
  logic        data_in_ready;
  logic        reload;
  logic        load_done;
  logic [5:0]  address0;
  logic        ce0;
  logic [15:0] q0;

  logic [15:0] d2 [2];
  logic        v2, rdy2, rl2, done2, ce2;
  logic [4:0]  addr2;
  logic [31:0] q2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] model [32];
  logic [15:0] rd_q [$];
  logic [15:0] last_q;
  int          exp_wr;
  bit          exp_load;

  always #5 clk = ~clk;

  encoder_param_stream_loader dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .reload(reload), .load_done(load_done),
    .address0(address0), .ce0(ce0), .q0(q0)
  );

  encoder_param_stream_loader #(.PARALLELISM_DIM_0(2)) dut2 (
    .clk(clk), .rst(rst), .data_in(d2), .data_in_valid(v2),
    .data_in_ready(rdy2), .reload(rl2), .load_done(done2),
    .address0(addr2), .ce0(ce2), .q0(q2)
  );

  // One clock of stimulus on the 1-lane instance; expected read data is taken
  // from the model before this edge's write, so same-address reads see the old word.
  task automatic step(input bit v, input logic [15:0] d, input bit rl,
                      input bit ce, input logic [5:0] a);
    bit exp_ready;
    data_in[0] = d; data_in_valid = v; reload = rl; ce0 = ce; address0 = a;
    exp_ready = exp_load && !rl;
    if (ce) rd_q.push_back((a < 6'd32) ? model[a[4:0]] : 16'h0000);
    #1;
    n_checks++;
    if (data_in_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL ready @%0t: got %b expected %b", $time, data_in_ready, exp_ready);
    end
    @(negedge clk);
    if (rl) begin
      exp_load = 1'b1;
      exp_wr   = 0;
    end else if (v && exp_ready) begin
      model[exp_wr] = d;
      if (exp_wr == 31) begin
        exp_wr   = 0;
        exp_load = 1'b0;
      end else begin
        exp_wr++;
      end
    end
    n_checks++;
    if (load_done !== !exp_load) begin
      n_fail++;
      $display("FAIL load_done @%0t: got %b expected %b", $time, load_done, !exp_load);
    end
    if (ce) last_q = rd_q.pop_front();
    n_checks++;
    if (q0 !== last_q) begin
      n_fail++;
      $display("FAIL q0 @%0t: got %h expected %h", $time, q0, last_q);
    end
  endtask

  task automatic do_reset(input bit rl);
    rst = 1'b1; reload = rl; data_in_valid = 1'b0; ce0 = 1'b1; address0 = 6'd3;
    v2 = 1'b0; rl2 = rl; ce2 = 1'b1; addr2 = 5'd1;
    @(negedge clk);
    n_checks++;
    if (load_done !== 1'b0 || done2 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_load_done: got %b/%b expected 0/0", load_done, done2);
    end
    n_checks++;
    if (q0 !== 16'h0000 || q2 !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_q0: got %h/%h expected 0/0", q0, q2);
    end
    rst = 1'b0; reload = 1'b0; ce0 = 1'b0; rl2 = 1'b0; ce2 = 1'b0;
    #1;
    n_checks++;
    if (data_in_ready !== 1'b1 || rdy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready: got %b/%b expected 1/1", data_in_ready, rdy2);
    end
    rd_q.delete();
    rd_q.push_back(16'h0000);
    last_q   = 16'h0000;
    exp_load = 1'b1;
    exp_wr   = 0;
    @(negedge clk);
  endtask

  task automatic read_sweep();
    for (int a = 0; a <= 32; a++) step(1'b0, 16'h0, 1'b0, 1'b1, 6'(a));
    step(1'b0, 16'h0, 1'b0, 1'b1, 6'd0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 6'd0);
  endtask

  task automatic load_until_done(input logic [15:0] base, input int budget);
    int cyc = 0;
    while (exp_load && cyc < budget) begin
      step(1'b1, base + 16'(exp_wr), 1'b0, 1'b0, 6'd0);
      cyc++;
    end
    n_checks++;
    if (exp_load) begin
      n_fail++;
      $display("FAIL load_timeout: got %0d beats expected 32", exp_wr);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
  endtask

  task automatic test_sequential_load();
    for (int i = 0; i < 32; i++) step(1'b1, 16'(i + 1), 1'b0, 1'b0, 6'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'hDEAD, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic test_read_sweep();
    read_sweep();
  endtask

  task automatic test_lanes();
    d2[0] = 16'h1234; d2[1] = 16'hBEEF; v2 = 1'b1;
    #1;
    n_checks++;
    if (rdy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL lanes_ready: got %b expected 1", rdy2);
    end
    @(negedge clk);
    d2[0] = 16'hFFFF; d2[1] = 16'h0000;
    @(negedge clk);
    v2 = 1'b0; ce2 = 1'b1; addr2 = 5'd0;
    @(negedge clk);
    addr2 = 5'd1;
    @(negedge clk);
    n_checks++;
    if (q2 !== 32'hBEEF1234) begin
      n_fail++;
      $display("FAIL lanes_word0: got %h expected beef1234", q2);
    end
    @(negedge clk);
    n_checks++;
    if (q2 !== 32'h0000FFFF) begin
      n_fail++;
      $display("FAIL lanes_word1: got %h expected 0000ffff", q2);
    end
    n_checks++;
    if (done2 !== 1'b0) begin
      n_fail++;
      $display("FAIL lanes_done: got %b expected 0", done2);
    end
    ce2 = 1'b0;
  endtask

  task automatic test_random_gaps();
    int cyc = 0;
    step(1'b0, 16'h0, 1'b1, 1'b0, 6'd0);
    while (exp_load && cyc < 400) begin
      step(($urandom_range(0, 2) != 0), 16'($urandom), 1'b0,
           1'($urandom_range(0, 1)), 6'($urandom_range(0, 33)));
      cyc++;
    end
    n_checks++;
    if (exp_load) begin
      n_fail++;
      $display("FAIL random_timeout: got %0d beats expected 32", exp_wr);
    end
    read_sweep();
  endtask

  task automatic test_reload();
    step(1'b0, 16'h0, 1'b1, 1'b0, 6'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 6'd0);
    step(1'b1, 16'h7777, 1'b1, 1'b0, 6'd0);
    for (int i = 0; i < 32; i++) step(1'b1, 16'hA5A5, 1'b0, 1'b0, 6'd0);
    read_sweep();
  endtask

  task automatic test_reset_mid_load();
    step(1'b0, 16'h0, 1'b1, 1'b0, 6'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0, 6'd0);
    do_reset(1'b0);
    load_until_done(16'h5A00, 40);
    read_sweep();
    do_reset(1'b1);
    load_until_done(16'hC300, 40);
    read_sweep();
  endtask

  initial begin
    rst = 1'b0; reload = 1'b0; data_in_valid = 1'b0; ce0 = 1'b0; address0 = '0;
    data_in[0] = '0; d2[0] = '0; d2[1] = '0; v2 = 1'b0; rl2 = 1'b0; ce2 = 1'b0; addr2 = '0;
    for (int i = 0; i < 32; i++) model[i] = 16'h0000;
    @(negedge clk);
    test_reset();
    test_sequential_load();
    test_read_sweep();
    test_lanes();
    test_random_gaps();
    test_reload();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
